ps2_mouse_rx: RTL and testbench

//  Receives PS/2 mouse frames from the board PS2Clk/PS2Data lines and assembles 3-byte movement packets.

---
 rtl/snake_mouse_pkg.sv | 33 +++
 rtl/ps2_rx_byte.sv | 110 +++++++++++
 rtl/ps2_mouse_rx.sv | 104 ++++++++++
 tb/tb_ps2_mouse_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
// The state enum and packet header layout are used by ps2_rx_byte and ps2_mouse_rx.
package snake_mouse_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_PKT_BYTES  = 3;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    typedef struct packed {
        logic yo;
        logic xo;
        logic ys;
        logic xs;
        logic one;
        logic m;
        logic r;
        logic l;
    } mouse_hdr_t;

    // Clamp a signed 13-bit position sum into 0..maxv.
    function automatic logic [11:0] clamp_pos(input logic signed [12:0] v,
                                              input logic [11:0] maxv);
        if (v < 0) begin
            return 12'd0;
        end else if (v > $signed({1'b0, maxv})) begin
            return maxv;
        end else begin
            return v[11:0];
        end
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: pin synchronizer, falling-edge detect, frame FSM, idle timeout.
// Odd parity is checked only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_byte
    import snake_mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 150_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       abort
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          din;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [CW-1:0] tcnt;
    logic          timed_out;
    logic          par_ok;

    assign fall = clk_prev & ~clk_sync[1];
    assign din  = data_sync[1];

    // The registered abort suppresses a repeat while the packet index is still clearing.
    assign timed_out = (tcnt == CW'(TIMEOUT_CYCLES)) && ((state != IDLE) || pkt_busy) && !abort;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;
    assign par_ok = ^{shreg, parity_bit};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_err   <= 1'b0;
            abort      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            abort      <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!din) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= din;
`endif
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (din && par_ok) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            byte_err <= 1'b1;
                        end
                    end
                endcase
            end else if (timed_out) begin
                state <= IDLE;
                abort <= 1'b1;
            end else if (tcnt != CW'(TIMEOUT_CYCLES)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet assembler: integrates 3-byte movement packets into a clamped cursor.
// Define PS2_PARITY_CHECK_EN to reject bytes with bad odd parity.
module ps2_mouse_rx
    import snake_mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 150_000,
    parameter int unsigned X_MAX          = 1023,
    parameter int unsigned Y_MAX          = 767
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [2:0]  btn,
    output logic        pkt_valid,
    output logic        frame_err
);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_err;
    logic              abort;
    logic [1:0]        byte_idx;
    logic              yo_q, xo_q, ys_q, xs_q;
    logic [2:0]        btn_hdr_q;
    logic [7:0]        dx_byte_q;
    mouse_hdr_t        hdr;
    logic signed [12:0] dx_ext, dy_ext, x_sum, y_sum;

    ps2_rx_byte #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .pkt_busy   (byte_idx != 2'd0),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .abort      (abort)
    );

    assign hdr = mouse_hdr_t'(byte_data);

    // dy comes straight from the byte being accepted; Y grows downward on screen.
    always_comb begin
        dx_ext = xo_q ? 13'sd0 : $signed({{4{xs_q}}, xs_q, dx_byte_q});
        dy_ext = yo_q ? 13'sd0 : $signed({{4{ys_q}}, ys_q, byte_data});
        x_sum  = $signed({1'b0, xpos}) + dx_ext;
        y_sum  = $signed({1'b0, ypos}) - dy_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xpos      <= 12'((X_MAX + 1) / 2);
            ypos      <= 12'((Y_MAX + 1) / 2);
            btn       <= 3'd0;
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            byte_idx  <= 2'd0;
            yo_q      <= 1'b0;
            xo_q      <= 1'b0;
            ys_q      <= 1'b0;
            xs_q      <= 1'b0;
            btn_hdr_q <= 3'd0;
            dx_byte_q <= 8'd0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            if (byte_err || abort) begin
                frame_err <= 1'b1;
                byte_idx  <= 2'd0;
            end else if (byte_valid) begin
                case (byte_idx)
                    2'd0: begin
                        if (hdr.one) begin
                            yo_q      <= hdr.yo;
                            xo_q      <= hdr.xo;
                            ys_q      <= hdr.ys;
                            xs_q      <= hdr.xs;
                            btn_hdr_q <= {hdr.m, hdr.r, hdr.l};
                            byte_idx  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        dx_byte_q <= byte_data;
                        byte_idx  <= 2'd2;
                    end
                    default: begin
                        xpos      <= clamp_pos(x_sum, 12'(X_MAX));
                        ypos      <= clamp_pos(y_sum, 12'(Y_MAX));
                        btn       <= btn_hdr_q;
                        pkt_valid <= 1'b1;
                        byte_idx  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: bit-banged PS/2 frames with hand-computed cursor results.
// Honours PS2_PARITY_CHECK_EN for the parity case.
module tb_ps2_mouse_rx;

    localparam int unsigned TO = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] xpos, ypos;
    logic [2:0]  btn;
    logic        pkt_valid, frame_err;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int pv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int pv0, fe0;

    ps2_mouse_rx #(
        .TIMEOUT_CYCLES(TO),
        .X_MAX(1023),
        .Y_MAX(767)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .xpos      (xpos),
        .ypos      (ypos),
        .btn       (btn),
        .pkt_valid (pkt_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_valid) pv_cnt++;
            if (frame_err) fe_cnt++;
            if (pkt_valid && frame_err) both_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = fr[i];
            wait_clks(10);
            ps2_clk = 1'b0;
            wait_clks(20);
            ps2_clk = 1'b1;
            wait_clks(10);
        end
        ps2_data = 1'b1;
        wait_clks(30);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0, 1'b0);
        send_byte(b1, 1'b0, 1'b0);
        send_byte(b2, 1'b0, 1'b0);
    endtask

    task automatic mark;
        @(negedge clk);
        pv0 = pv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        wait_clks(4);
        @(negedge clk);
        check("reset_xpos", 32'(xpos), 512);
        check("reset_ypos", 32'(ypos), 384);
        check("reset_btn", 32'(btn), 0);
        check("reset_pv", 32'(pkt_valid), 0);
        check("reset_fe", 32'(frame_err), 0);
        rst = 1'b0;

        mark();
        send_pkt(8'h08, 8'h05, 8'h03);
        @(negedge clk);
        check("p1_pv_once", 32'(pv_cnt - pv0), 1);
        check("p1_xpos", 32'(xpos), 517);
        check("p1_ypos", 32'(ypos), 381);
        check("p1_btn", 32'(btn), 0);

        send_pkt(8'h19, 8'hF0, 8'h00);
        @(negedge clk);
        check("left_xpos", 32'(xpos), 501);
        check("left_ypos", 32'(ypos), 381);
        check("left_btn", 32'(btn), 1);

        send_pkt(8'h18, 8'h01, 8'h00);
        @(negedge clk);
        check("xneg_1", 32'(xpos), 246);
        send_pkt(8'h18, 8'h01, 8'h00);
        @(negedge clk);
        check("xneg_sat", 32'(xpos), 0);
        send_pkt(8'h18, 8'h01, 8'h00);
        @(negedge clk);
        check("xneg_nowrap", 32'(xpos), 0);
        check("xneg_btn", 32'(btn), 0);

        send_pkt(8'h08, 8'h00, 8'hFF);
        @(negedge clk);
        check("yup_1", 32'(ypos), 126);
        send_pkt(8'h08, 8'h00, 8'hFF);
        @(negedge clk);
        check("yup_sat", 32'(ypos), 0);

        for (int i = 0; i < 5; i++) send_pkt(8'h08, 8'hFF, 8'h00);
        @(negedge clk);
        check("xpos_sat_max", 32'(xpos), 1023);

        send_pkt(8'h4A, 8'h80, 8'h00);
        @(negedge clk);
        check("xovf_hold", 32'(xpos), 1023);
        check("xovf_btn", 32'(btn), 2);

        mark();
        send_byte(8'h00, 1'b0, 1'b0);
        send_pkt(8'h38, 8'hFF, 8'hFE);
        @(negedge clk);
        check("badhdr_pv", 32'(pv_cnt - pv0), 1);
        check("badhdr_fe", 32'(fe_cnt - fe0), 0);
        check("badhdr_xpos", 32'(xpos), 1022);
        check("badhdr_ypos", 32'(ypos), 2);

        mark();
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        @(negedge clk);
        check("badstop_fe", 32'(fe_cnt - fe0), 1);
        check("badstop_pv", 32'(pv_cnt - pv0), 0);
        check("badstop_xpos", 32'(xpos), 1022);
        send_pkt(8'h18, 8'hFE, 8'h00);
        @(negedge clk);
        check("after_stop_xpos", 32'(xpos), 1020);
        check("after_stop_pv", 32'(pv_cnt - pv0), 1);

        mark();
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        wait_clks(TO + 500);
        @(negedge clk);
        check("timeout_fe_once", 32'(fe_cnt - fe0), 1);
        check("timeout_pv", 32'(pv_cnt - pv0), 0);
        send_pkt(8'h08, 8'h03, 8'h01);
        @(negedge clk);
        check("after_to_xpos", 32'(xpos), 1023);
        check("after_to_ypos", 32'(ypos), 1);

        mark();
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b1);
        @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        check("par_fe", 32'(fe_cnt - fe0), 1);
        check("par_pv", 32'(pv_cnt - pv0), 0);
        check("par_ypos", 32'(ypos), 1);
        check("par_btn", 32'(btn), 0);
`else
        check("par_fe", 32'(fe_cnt - fe0), 0);
        check("par_pv", 32'(pv_cnt - pv0), 1);
        check("par_ypos", 32'(ypos), 0);
        check("par_btn", 32'(btn), 1);
`endif

        send_byte(8'h08, 1'b0, 1'b0);
        rst = 1'b1;
        wait_clks(2);
        @(negedge clk);
        check("midrst_xpos", 32'(xpos), 512);
        check("midrst_ypos", 32'(ypos), 384);
        check("midrst_btn", 32'(btn), 0);
        rst = 1'b0;
        send_pkt(8'h08, 8'h01, 8'h01);
        @(negedge clk);
        check("postrst_xpos", 32'(xpos), 513);
        check("postrst_ypos", 32'(ypos), 383);

        check("no_overlap", 32'(both_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
